conv_egress: RTL and testbench
==============================

CONV_EGRESS -- requirements
Module: conv_egress

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which sets the output FIFO entry count; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port arst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port res_vld_i, input, 1 bit: a convolution result beat is present.
REQ-005 The block SHALL have port res_data_i, input, conv_pkg::pixel_t: the result pixel.
REQ-006 The block SHALL have port res_pos_i, input, conv_pkg::kernel_pos_t: the boundary flags {w2,w1,e2,e1,n2,n1,s2,s1} of the result pixel.
REQ-007 The block SHALL have port res_rdy_o, output, 1 bit: the block can accept a result beat.
REQ-008 The block SHALL have port m_tvalid_o, output, 1 bit: AXI-Stream master valid.
REQ-009 The block SHALL have port m_tdata_o, output, conv_pkg::pixel_t: AXI-Stream master data.
REQ-010 The block SHALL have port m_tuser_o, output, 1 bit: start of frame.
REQ-011 The block SHALL have port m_tlast_o, output, 1 bit: end of line.
REQ-012 The block SHALL have port m_tready_i, input, 1 bit: downstream ready.
REQ-013 The block SHALL have port frame_done_o, output, 1 bit: one-cycle pulse marking the egress of the last pixel of a frame.
REQ-014 The block SHALL have port err_o, output, 1 bit: sticky protocol error flag.

Function
REQ-015 A beat SHALL be accepted exactly in a cycle where res_vld_i=1 and res_rdy_o=1.
REQ-016 res_rdy_o SHALL equal (FIFO not full).
REQ-017 res_rdy_o SHALL have no combinational path from m_tready_i.
REQ-018 The per-beat flags SHALL be derived as follows.
- sof = res_pos_i.n2 & res_pos_i.w2
- eol = res_pos_i.e2
- eof = res_pos_i.s2 & res_pos_i.e2
REQ-019 The block SHALL implement a frame state machine with states IDLE and ACTIVE, reset to IDLE.
REQ-020 In IDLE, an accepted beat with sof=1 SHALL be written to the FIFO and SHALL move the state to ACTIVE, unless eof=1 on the same beat (1x1 frame), in which case the state SHALL remain IDLE.
REQ-021 In IDLE, an accepted beat with sof=0 SHALL be dropped and SHALL set err_o.
REQ-022 In ACTIVE, every accepted beat SHALL be written to the FIFO.
REQ-023 In ACTIVE, an accepted beat with sof=1 SHALL set err_o and SHALL be forwarded as a new frame start.
REQ-024 In ACTIVE, an accepted beat with eof=1 SHALL return the state to IDLE.
REQ-025 Each FIFO entry SHALL store {data, sof, eol}; the FIFO SHALL have DEPTH entries, in-order, with wrap-around read and write pointers.
REQ-026 The FIFO SHALL have no write-to-read bypass: a beat accepted in cycle N SHALL appear on m_* no earlier than cycle N+1.
REQ-027 m_tvalid_o SHALL equal (FIFO not empty); m_tdata_o, m_tuser_o and m_tlast_o SHALL present the head entry.
REQ-028 The head entry SHALL be popped exactly when m_tvalid_o=1 and m_tready_i=1.
REQ-029 While m_tvalid_o=1 and m_tready_i=0, m_tdata_o, m_tuser_o and m_tlast_o SHALL hold stable.
REQ-030 A simultaneous push and pop SHALL leave the occupancy unchanged; this SHALL be legal at any non-full occupancy, including empty (push only is effective) and DEPTH-1.
REQ-031 When full, res_rdy_o SHALL be 0 even if a pop occurs in the same cycle.
REQ-032 The FIFO SHALL keep an eof marker per entry (DEPTH x 1 bit); frame_done_o SHALL pulse in the cycle the eof entry is popped.
REQ-033 err_o SHALL stay set until reset; no other event SHALL clear it.
REQ-034 The occupancy counter SHALL be clog2(DEPTH)+1 bits wide, and the FIFO SHALL never overflow or underflow.

Reset
REQ-035 Asserting arst_n low SHALL immediately produce the following.
- FIFO emptied
- state IDLE
- m_tvalid_o=0, frame_done_o=0, err_o=0
- res_rdy_o=1
REQ-036 m_tdata_o, m_tuser_o and m_tlast_o SHALL be don't-care while m_tvalid_o=0.
REQ-037 Reset asserted mid-frame SHALL discard buffered beats, and no partial beat SHALL appear after release.
REQ-038 The first cycle after release SHALL accept input.

Verification
REQ-039 Scenario "nominal frame": 4x3 frame with pos flags set per position and m_tready_i=1 -> 12 beats, tuser only on beat 0, tlast on beats 3, 7 and 11, frame_done_o pulses with beat 11, err_o=0.
REQ-040 Scenario "back-pressure": m_tready_i=0 while 4 beats are pushed with DEPTH=4 -> res_rdy_o=0 after the 4th accept; m_tdata_o holds beat 0; release drains the FIFO in order with no loss.
REQ-041 Scenario "stray beat": a beat with sof=0 in IDLE -> no m_tvalid_o, err_o=1 next cycle and stays 1; a following sof beat is forwarded normally.
REQ-042 Scenario "early SOF": sof arrives mid-frame -> err_o=1, the beat is forwarded with m_tuser_o=1, and the frame continues.
REQ-043 Scenario "simultaneous push/pop": at occupancy 3 of 4 with push and pop in the same cycle -> occupancy stays 3 and res_rdy_o stays 1.
REQ-044 Scenario "reset mid-frame": arst_n asserted with 2 beats buffered -> m_tvalid_o=0 asynchronously; after release, the next sof beat emerges first.

Source files
------------

// File: rtl/conv_egress.sv
// Egress stage for the convolution pipeline: frames result beats into AXI-Stream
// (tuser = start of frame, tlast = end of line) through a small in-order FIFO.
package conv_pkg;
    typedef logic [7:0] pixel_t;
    typedef struct packed {
        logic w2;
        logic w1;
        logic e2;
        logic e1;
        logic n2;
        logic n1;
        logic s2;
        logic s1;
    } kernel_pos_t;
endpackage

module conv_egress #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  res_vld_i,
    input  conv_pkg::pixel_t      res_data_i,
    input  conv_pkg::kernel_pos_t res_pos_i,
    output logic                  res_rdy_o,
    output logic                  m_tvalid_o,
    output conv_pkg::pixel_t      m_tdata_o,
    output logic                  m_tuser_o,
    output logic                  m_tlast_o,
    input  logic                  m_tready_i,
    output logic                  frame_done_o,
    output logic                  err_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {StIdle, StActive} state_e;

    state_e                state_q, state_d;
    logic                  err_q, err_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    conv_pkg::pixel_t      data_q [DEPTH];
    conv_pkg::pixel_t      data_d [DEPTH];
    logic [DEPTH-1:0]      sof_q, sof_d;
    logic [DEPTH-1:0]      eol_q, eol_d;
    logic [DEPTH-1:0]      eof_q, eof_d;

    logic sof, eol, eof;
    logic full, empty;
    logic accept, push, pop;
    logic unused_pos;

    assign sof = res_pos_i.n2 & res_pos_i.w2;
    assign eol = res_pos_i.e2;
    assign eof = res_pos_i.s2 & res_pos_i.e2;
    assign unused_pos = ^{res_pos_i.w1, res_pos_i.e1, res_pos_i.n1, res_pos_i.s1};

    // Ready is a function of occupancy only, so m_tready_i never reaches res_rdy_o.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = res_vld_i & ~full;
    assign pop    = ~empty & m_tready_i;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        push    = 1'b0;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (sof) begin
                        push = 1'b1;
                        if (!eof) state_d = StActive;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StActive: begin
                    push = 1'b1;
                    if (sof) err_d = 1'b1;
                    if (eof) state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        data_d   = data_q;
        sof_d    = sof_q;
        eol_d    = eol_q;
        eof_d    = eof_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            data_d[wr_ptr_q] = res_data_i;
            sof_d[wr_ptr_q]  = sof;
            eol_d[wr_ptr_q]  = eol;
            eof_d[wr_ptr_q]  = eof;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= StIdle;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '{default: '0};
            sof_q    <= '0;
            eol_q    <= '0;
            eof_q    <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
        end
    end

    assign res_rdy_o    = ~full;
    assign m_tvalid_o   = ~empty;
    assign m_tdata_o    = data_q[rd_ptr_q];
    assign m_tuser_o    = sof_q[rd_ptr_q];
    assign m_tlast_o    = eol_q[rd_ptr_q];
    assign frame_done_o = pop & eof_q[rd_ptr_q];
    assign err_o        = err_q;
endmodule

// File: tb/tb_conv_egress.sv
// Self-checking bench for conv_egress: queue-based frame/FIFO model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_conv_egress;
    localparam int unsigned DEPTH = 4;

    logic                  clk;
    logic                  arst_n;
    logic                  res_vld_i;
    conv_pkg::pixel_t      res_data_i;
    conv_pkg::kernel_pos_t res_pos_i;
    logic                  res_rdy_o;
    logic                  m_tvalid_o;
    conv_pkg::pixel_t      m_tdata_o;
    logic                  m_tuser_o;
    logic                  m_tlast_o;
    logic                  m_tready_i;
    logic                  frame_done_o;
    logic                  err_o;

    conv_egress #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .res_vld_i    (res_vld_i),
        .res_data_i   (res_data_i),
        .res_pos_i    (res_pos_i),
        .res_rdy_o    (res_rdy_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tdata_o    (m_tdata_o),
        .m_tuser_o    (m_tuser_o),
        .m_tlast_o    (m_tlast_o),
        .m_tready_i   (m_tready_i),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eol;
        logic       eof;
    } ent_t;

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
        logic       f;
    } obs_t;

    int   checks   = 0;
    int   failures = 0;
    ent_t mq[$];
    obs_t log_q[$];
    logic in_frame = 1'b0;
    logic err_m    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic conv_pkg::kernel_pos_t mkpos(int x, int y, int w, int h);
        conv_pkg::kernel_pos_t p;
        p.w2 = (x == 0);
        p.w1 = (x <= 1);
        p.e2 = (x == w - 1);
        p.e1 = (x >= w - 2);
        p.n2 = (y == 0);
        p.n1 = (y <= 1);
        p.s2 = (y == h - 1);
        p.s1 = (y >= h - 2);
        return p;
    endfunction

    // Model: frame rules applied to a queue of expected beats, checked each negedge.
    always @(negedge clk) begin
        if (!arst_n) begin
            mq.delete();
            in_frame = 1'b0;
            err_m    = 1'b0;
            check("rst_tvalid", m_tvalid_o, 0);
            check("rst_rdy", res_rdy_o, 1);
            check("rst_err", err_o, 0);
            check("rst_done", frame_done_o, 0);
        end else begin
            logic m_rdy, m_vld, b_sof, b_eol, b_eof, acc;
            m_rdy = (mq.size() != DEPTH);
            m_vld = (mq.size() != 0);
            check("rdy", res_rdy_o, m_rdy);
            check("tvalid", m_tvalid_o, m_vld);
            check("err", err_o, err_m);
            if (m_vld) begin
                check("tdata", m_tdata_o, mq[0].d);
                check("tuser", m_tuser_o, mq[0].sof);
                check("tlast", m_tlast_o, mq[0].eol);
                check("frame_done", frame_done_o, m_tready_i & mq[0].eof);
            end else begin
                check("frame_done_idle", frame_done_o, 0);
            end
            if (m_vld && m_tready_i) begin
                log_q.push_back('{d: m_tdata_o, u: m_tuser_o, l: m_tlast_o, f: frame_done_o});
                void'(mq.pop_front());
            end
            b_sof = res_pos_i.n2 && res_pos_i.w2;
            b_eol = res_pos_i.e2;
            b_eof = res_pos_i.s2 && res_pos_i.e2;
            acc   = res_vld_i && m_rdy;
            if (acc) begin
                if (!in_frame) begin
                    if (b_sof) begin
                        mq.push_back('{d: res_data_i, sof: b_sof, eol: b_eol, eof: b_eof});
                        in_frame = !b_eof;
                    end else begin
                        err_m = 1'b1;
                    end
                end else begin
                    mq.push_back('{d: res_data_i, sof: b_sof, eol: b_eol, eof: b_eof});
                    if (b_sof) err_m = 1'b1;
                    if (b_eof) in_frame = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input conv_pkg::kernel_pos_t p);
        int n;
        res_vld_i  = 1'b1;
        res_data_i = d;
        res_pos_i  = p;
        n = 0;
        while (!res_rdy_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accept", res_rdy_o, 1);
        @(posedge clk);
        #1;
        res_vld_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (m_tvalid_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", m_tvalid_o, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        arst_n     = 1'b0;
        res_vld_i  = 1'b0;
        m_tready_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        log_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        arst_n     = 1'b0;
        res_vld_i  = 1'b0;
        res_data_i = '0;
        res_pos_i  = '0;
        m_tready_i = 1'b0;
        #12;
        check("init_tvalid", m_tvalid_o, 0);
        check("init_rdy", res_rdy_o, 1);
        check("init_err", err_o, 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        check("release_rdy", res_rdy_o, 1);

        // Nominal 4x3 frame, downstream always ready.
        m_tready_i = 1'b1;
        for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), mkpos(i % 4, i / 4, 4, 3));
        wait_drain();
        check("nom_count", log_q.size(), 12);
        check("nom_user0", log_q[0].u, 1);
        check("nom_user1", log_q[1].u, 0);
        check("nom_last3", log_q[3].l, 1);
        check("nom_last7", log_q[7].l, 1);
        check("nom_last10", log_q[10].l, 0);
        check("nom_last11", log_q[11].l, 1);
        check("nom_done10", log_q[10].f, 0);
        check("nom_done11", log_q[11].f, 1);
        check("nom_data11", log_q[11].d, 8'h1b);
        check("nom_err", err_o, 0);

        // Stray beat in idle, then a normal 2x1 frame.
        do_reset();
        m_tready_i = 1'b1;
        send(8'h55, mkpos(1, 1, 4, 3));
        check("stray_err", err_o, 1);
        check("stray_tvalid", m_tvalid_o, 0);
        @(posedge clk);
        #1;
        check("stray_tvalid2", m_tvalid_o, 0);
        send(8'h60, mkpos(0, 0, 2, 1));
        send(8'h61, mkpos(1, 0, 2, 1));
        wait_drain();
        check("stray_count", log_q.size(), 2);
        check("stray_d0", log_q[0].d, 8'h60);
        check("stray_u0", log_q[0].u, 1);
        check("stray_l1", log_q[1].l, 1);
        check("stray_f1", log_q[1].f, 1);
        check("stray_err_sticky", err_o, 1);

        // Early SOF mid-frame: flagged, forwarded as a new start, frame continues.
        do_reset();
        m_tready_i = 1'b1;
        for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), mkpos(i % 4, i / 4, 4, 3));
        check("esof_err_before", err_o, 0);
        send(8'he0, mkpos(0, 0, 4, 3));
        check("esof_err", err_o, 1);
        for (int i = 1; i < 12; i++) send(8'h30 + 8'(i), mkpos(i % 4, i / 4, 4, 3));
        wait_drain();
        check("esof_count", log_q.size(), 18);
        check("esof_d6", log_q[6].d, 8'he0);
        check("esof_u6", log_q[6].u, 1);
        nf = 0;
        foreach (log_q[i]) nf += int'(log_q[i].f);
        check("esof_done_count", nf, 1);
        check("esof_f17", log_q[17].f, 1);

        // Back-pressure: fill to DEPTH, head holds, then drains in order.
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), mkpos(i % 4, i / 4, 4, 3));
        check("bp_rdy", res_rdy_o, 0);
        check("bp_tvalid", m_tvalid_o, 1);
        check("bp_head", m_tdata_o, 8'h40);
        repeat (3) @(posedge clk);
        #1;
        check("bp_head_hold", m_tdata_o, 8'h40);
        check("bp_rdy_hold", res_rdy_o, 0);
        m_tready_i = 1'b1;
        wait_drain();
        check("bp_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) check("bp_order", log_q[i].d, 8'h40 + 8'(i));

        // Simultaneous push/pop at occupancy DEPTH-1.
        do_reset();
        for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), mkpos(i % 4, i / 4, 4, 3));
        check("pp_rdy3", res_rdy_o, 1);
        m_tready_i = 1'b1;
        send(8'h53, mkpos(3, 0, 4, 3));
        m_tready_i = 1'b0;
        check("pp_rdy_after", res_rdy_o, 1);
        check("pp_head", m_tdata_o, 8'h51);
        send(8'h54, mkpos(0, 1, 4, 3));
        check("pp_full", res_rdy_o, 0);
        m_tready_i = 1'b1;
        wait_drain();
        check("pp_count", log_q.size(), 5);
        check("pp_last", log_q[4].d, 8'h54);

        // Reset mid-frame with two beats buffered.
        do_reset();
        send(8'h70, mkpos(0, 0, 4, 3));
        send(8'h71, mkpos(1, 0, 4, 3));
        check("rmf_tvalid_pre", m_tvalid_o, 1);
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        check("rmf_tvalid_async", m_tvalid_o, 0);
        check("rmf_rdy_async", res_rdy_o, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        log_q.delete();
        check("rmf_rdy_release", res_rdy_o, 1);
        m_tready_i = 1'b1;
        send(8'ha5, mkpos(0, 0, 2, 1));
        send(8'ha6, mkpos(1, 0, 2, 1));
        wait_drain();
        check("rmf_count", log_q.size(), 2);
        check("rmf_first", log_q[0].d, 8'ha5);

        // 1x1 frames: sof and eof on one beat keep the block idle without error.
        do_reset();
        m_tready_i = 1'b1;
        send(8'h90, mkpos(0, 0, 1, 1));
        send(8'h91, mkpos(0, 0, 1, 1));
        wait_drain();
        check("one_count", log_q.size(), 2);
        check("one_f0", log_q[0].f, 1);
        check("one_f1", log_q[1].f, 1);
        check("one_u1", log_q[1].u, 1);
        check("one_err", err_o, 0);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
